vfp_config_axi4l_master: RTL and testbench
==========================================

// Module: vfp_config_axi4l_master
// PURPOSE
//  Command-driven AXI4-Lite master that feeds the VFP vfpconfig slave port (the ConfigMaster side).
//  - Accepts single register read/write commands over a valid/ready channel.
//  - Runs one AXI4-Lite transaction per command and returns a response with data, RESP and timeout flag.
//  - Sits between the test/sequencer or CPU-side command source and the VFP configuration registers.
// PARAMETERS
//  C_vfpConfig_DATA_WIDTH  32    AXI4-Lite data width (32 only)
//  C_vfpConfig_ADDR_WIDTH  8     AXI4-Lite byte-address width
//  TIMEOUT_CYCLES          1024  cycles in any wait state before abort; must be >= 2
// PORTS
//  ACLK        in   1   sole clock
//  ARESET      in   1   asynchronous reset, active-high
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when cmd_valid & cmd_ready
//  cmd_write   in   1   1 = write, 0 = read
//  cmd_addr    in   AW  byte address (AW = C_vfpConfig_ADDR_WIDTH)
//  cmd_wdata   in   DW  write data (DW = C_vfpConfig_DATA_WIDTH)
//  cmd_wstrb   in   DW/8  write byte strobes
//  rsp_valid   out  1   response present, held until rsp_ready
//  rsp_ready   in   1   response consumed
//  rsp_write   out  1   echo of cmd_write
//  rsp_rdata   out  DW  read data (0 for writes)
//  rsp_resp    out  2   BRESP or RRESP; 2'b10 on timeout
//  rsp_timeout out  1   transaction aborted by timeout
//  AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY,
//  ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY   standard AXI4-Lite master ports; AxPROT = 3'b000
// BEHAVIOUR
//  Reset values
//  - All outputs 0 while ARESET is high; state = IDLE; timeout counter = 0.
//  - cmd_ready is 1 in the first cycle after reset deasserts.
//  - Reset mid-transaction drops all VALIDs asynchronously; no response is produced.
//  FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP
//  - IDLE: cmd_ready = 1; on accept, register addr/data/strb/write.
//    Next state is WR_AW_W (write) or RD_AR (read). AxVALID rises in the cycle after accept.
//  - WR_AW_W: AWVALID and WVALID assert together.
//    Each drops on its own READY handshake; AWREADY and WREADY may arrive in either order or the same cycle.
//    Go to WR_B in the cycle after both handshakes are done. BREADY = 1 in WR_B only.
//  - WR_B: on BVALID, capture BRESP, go to RSP.
//  - RD_AR: ARVALID held until ARREADY, then go to RD_R. RREADY = 1 in RD_R only.
//  - RD_R: on RVALID, capture RDATA/RRESP, go to RSP.
//  - RSP: rsp_valid = 1 with stable fields. On rsp_ready, go to IDLE; cmd_ready returns the next cycle.
//  Protocol rules
//  - No pipelining: one outstanding transaction; cmd_ready = 0 outside IDLE.
//  - VALID never drops before its handshake and its payload stays stable (AXI rule).
//  - Address is passed through unmodified; unaligned addresses are not checked.
//  Timeout
//  - Counter clears on entering each wait state (WR_AW_W, WR_B, RD_AR, RD_R) and increments every cycle there.
//  - When it reaches TIMEOUT_CYCLES-1: drop all VALID/READY, set rsp_resp = 2'b10 and rsp_timeout = 1, go to RSP.
//  Response data
//  - rsp_rdata = 0 for writes and for timeouts.
// STRUCTURE
//  - Shared package vfp_config_pkg:
//    typedef enum logic [2:0] cfg_state_t;
//    localparams RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
//    typedef struct cfg_cmd_t {write, addr, wdata, wstrb};
//    typedef struct cfg_rsp_t {write, rdata, resp, timeout}.
//  - Single module, no sub-modules; the timeout counter is inline and $clog2(TIMEOUT_CYCLES) bits wide.
// TESTING
//  1. Write 0x10 = 0xDEADBEEF, slave AWREADY/WREADY same cycle, BRESP = 00
//     -> one AW and one W beat, rsp_valid with rsp_resp = 00 and rsp_timeout = 0.
//  2. Write, slave gives WREADY 3 cycles before AWREADY
//     -> WVALID drops after its handshake, AWVALID stays high; exactly one B accepted.
//  3. Read 0x04, slave returns RDATA = 0x0000_00A5 after 5 cycles
//     -> rsp_rdata = 0xA5, rsp_resp = 00, ARVALID high for 1 handshake only.
//  4. Read with slave never asserting RVALID, TIMEOUT_CYCLES = 16
//     -> after 16 cycles in RD_R: rsp_resp = 10, rsp_timeout = 1, RREADY drops.
//  5. rsp_ready held low 10 cycles
//     -> rsp fields stable, cmd_ready = 0; back-to-back command accepted 1 cycle after rsp_ready.
//  6. ARESET pulsed while AWVALID high
//     -> all VALIDs 0 immediately, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/vfp_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vfp_config_pkg
// Description : Shared types and constants for the VFP config AXI4-Lite master.
// Revision    : 1.0 - initial release
// ============================================================================
package vfp_config_pkg;

    localparam int CFG_DATA_WIDTH = 32;
    localparam int CFG_ADDR_WIDTH = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } cfg_state_t;

    typedef struct packed {
        logic                          write;
        logic [CFG_ADDR_WIDTH-1:0]     addr;
        logic [CFG_DATA_WIDTH-1:0]     wdata;
        logic [CFG_DATA_WIDTH/8-1:0]   wstrb;
    } cfg_cmd_t;

    typedef struct packed {
        logic                          write;
        logic [CFG_DATA_WIDTH-1:0]     rdata;
        logic [1:0]                    resp;
        logic                          timeout;
    } cfg_rsp_t;

    function automatic logic is_wait_state(input cfg_state_t s);
        return (s == ST_WR_AW_W) || (s == ST_WR_B) || (s == ST_RD_AR) || (s == ST_RD_R);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vfp_config_axi4l_master.sv
`default_nettype none
// ============================================================================
// Module      : vfp_config_axi4l_master
// Description : Command-driven single-transaction AXI4-Lite master for vfpconfig.
// Revision    : 1.0 - initial release
// ============================================================================
module vfp_config_axi4l_master
    import vfp_config_pkg::*;
#(
    parameter int C_vfpConfig_DATA_WIDTH = 32,
    parameter int C_vfpConfig_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES         = 1024
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_write,
    input  logic [C_vfpConfig_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_vfpConfig_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_vfpConfig_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic                                  rsp_write,
    output logic [C_vfpConfig_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                            rsp_resp,
    output logic                                  rsp_timeout,
    output logic [C_vfpConfig_ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                            AWPROT,
    output logic                                  AWVALID,
    input  logic                                  AWREADY,
    output logic [C_vfpConfig_DATA_WIDTH-1:0]     WDATA,
    output logic [C_vfpConfig_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                                  WVALID,
    input  logic                                  WREADY,
    input  logic [1:0]                            BRESP,
    input  logic                                  BVALID,
    output logic                                  BREADY,
    output logic [C_vfpConfig_ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                            ARPROT,
    output logic                                  ARVALID,
    input  logic                                  ARREADY,
    input  logic [C_vfpConfig_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                            RRESP,
    input  logic                                  RVALID,
    output logic                                  RREADY
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);

    cfg_state_t                             r_state;
    logic [c_CNT_W-1:0]                     r_cnt;
    cfg_rsp_t                               r_rsp;
    logic                                   r_rsp_valid;
    logic [C_vfpConfig_ADDR_WIDTH-1:0]      r_awaddr;
    logic                                   r_awvalid;
    logic [C_vfpConfig_DATA_WIDTH-1:0]      r_wdata;
    logic [C_vfpConfig_DATA_WIDTH/8-1:0]    r_wstrb;
    logic                                   r_wvalid;
    logic                                   r_bready;
    logic [C_vfpConfig_ADDR_WIDTH-1:0]      r_araddr;
    logic                                   r_arvalid;
    logic                                   r_rready;

    logic w_done;
    logic w_abort;

    // Condition that completes the current wait state; it always wins over a same-cycle timeout.
    always_comb begin
        w_done = 1'b0;
        case (r_state)
            ST_WR_AW_W: w_done = (!r_awvalid || AWREADY) && (!r_wvalid || WREADY);
            ST_WR_B:    w_done = BVALID;
            ST_RD_AR:   w_done = ARREADY;
            ST_RD_R:    w_done = RVALID;
            default:    w_done = 1'b0;
        endcase
    end

    assign w_abort = is_wait_state(r_state) && !w_done &&
                     (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else if (w_abort) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp.rdata   <= '0;
            r_rsp.resp    <= RESP_SLVERR;
            r_rsp.timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RSP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_rsp.write   <= cmd_write;
                        r_rsp.rdata   <= '0;
                        r_rsp.resp    <= RESP_OKAY;
                        r_rsp.timeout <= 1'b0;
                        r_cnt         <= '0;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_AW_W;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
                    if (w_done) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp.resp  <= BRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp.rdata <= RDATA;
                        r_rsp.resp  <= RRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by reset so the port reads 0 during reset and 1 as soon as it releases.
    assign cmd_ready   = (r_state == ST_IDLE) && !ARESET;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp.write;
    assign rsp_rdata   = r_rsp.rdata;
    assign rsp_resp    = r_rsp.resp;
    assign rsp_timeout = r_rsp.timeout;
    assign AWADDR      = r_awaddr;
    assign AWPROT      = 3'b000;
    assign AWVALID     = r_awvalid;
    assign WDATA       = r_wdata;
    assign WSTRB       = r_wstrb;
    assign WVALID      = r_wvalid;
    assign BREADY      = r_bready;
    assign ARADDR      = r_araddr;
    assign ARPROT      = 3'b000;
    assign ARVALID     = r_arvalid;
    assign RREADY      = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_vfp_config_axi4l_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_vfp_config_axi4l_master
// Description : Directed vector bench with a configurable AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vfp_config_axi4l_master;
    import vfp_config_pkg::*;

    localparam int c_TO    = 16;
    localparam int c_NEVER = 1000;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    vfp_config_axi4l_master #(
        .C_vfpConfig_DATA_WIDTH(32),
        .C_vfpConfig_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave behaviour settings (written by the main sequence only)
    int          s_aw_dly, s_w_dly, s_ar_dly, s_rsp_dly;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;

    // Slave-side observation counters (written by the slave process only)
    int          cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r, cnt_awonly, cnt_rr;
    logic [7:0]  cap_awaddr, cap_araddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    initial begin : slave
        int  aw_cnt, w_cnt, ar_cnt, resp_cnt;
        bit  aw_got, w_got, ar_got;
        bit  p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_ar = 0; cnt_r = 0; cnt_awonly = 0; cnt_rr = 0;
        cap_awaddr = 0; cap_araddr = 0; cap_wdata = 0; cap_wstrb = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; resp_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        forever begin
            @(posedge ACLK); #1;
            if (p_awv && p_awr) begin cnt_aw++; aw_got = 1; cap_awaddr = AWADDR; end
            if (p_wv && p_wr)   begin cnt_w++;  w_got = 1; cap_wdata = WDATA; cap_wstrb = WSTRB; end
            if (p_arv && p_arr) begin cnt_ar++; ar_got = 1; cap_araddr = ARADDR; end
            if (p_bv && p_br) cnt_b++;
            if (p_rv && p_rr) cnt_r++;
            if (AWVALID && !WVALID) cnt_awonly++;
            if (RREADY) cnt_rr++;
            if (ARESET || rsp_valid) begin
                aw_got = 0; w_got = 0; ar_got = 0; resp_cnt = 0;
                BVALID = 0; RVALID = 0;
            end else begin
                if (p_bv && p_br) begin
                    BVALID = 0; aw_got = 0; w_got = 0; resp_cnt = 0;
                end else if (aw_got && w_got && !BVALID) begin
                    if (resp_cnt >= s_rsp_dly) begin BVALID = 1; BRESP = s_resp; end
                    else resp_cnt++;
                end
                if (p_rv && p_rr) begin
                    RVALID = 0; ar_got = 0; resp_cnt = 0;
                end else if (ar_got && !RVALID) begin
                    if (resp_cnt >= s_rsp_dly) begin RVALID = 1; RDATA = s_rdata; RRESP = s_resp; end
                    else resp_cnt++;
                end
            end
            if (AWVALID && !ARESET) begin AWREADY = (aw_cnt >= s_aw_dly); aw_cnt++; end
            else begin AWREADY = 0; aw_cnt = 0; end
            if (WVALID && !ARESET)  begin WREADY = (w_cnt >= s_w_dly); w_cnt++; end
            else begin WREADY = 0; w_cnt = 0; end
            if (ARVALID && !ARESET) begin ARREADY = (ar_cnt >= s_ar_dly); ar_cnt++; end
            else begin ARREADY = 0; ar_cnt = 0; end
            p_awv = AWVALID; p_awr = AWREADY; p_wv = WVALID; p_wr = WREADY;
            p_bv = BVALID; p_br = BREADY; p_arv = ARVALID; p_arr = ARREADY;
            p_rv = RVALID; p_rr = RREADY;
        end
    end

    typedef struct {
        cfg_cmd_t    cmd;
        int          aw_dly, w_dly, ar_dly, rsp_dly;
        logic [1:0]  s_resp;
        logic [31:0] s_rdata;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic        e_to;
        int          e_aw, e_w, e_b, e_ar, e_r, e_awonly, e_rr;
    } vec_t;

    vec_t vecs[7];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input int awd, input int wdd,
                                input int ard, input int rspd, input logic [1:0] sr,
                                input logic [31:0] srd, input logic [1:0] xr,
                                input logic [31:0] xrd, input logic xto, input int xaw,
                                input int xw, input int xb, input int xar, input int xr_,
                                input int xawo, input int xrr);
        vec_t v;
        v.cmd = '{write: wr, addr: a, wdata: wd, wstrb: ws};
        v.aw_dly = awd; v.w_dly = wdd; v.ar_dly = ard; v.rsp_dly = rspd;
        v.s_resp = sr; v.s_rdata = srd; v.e_resp = xr; v.e_rdata = xrd; v.e_to = xto;
        v.e_aw = xaw; v.e_w = xw; v.e_b = xb; v.e_ar = xar; v.e_r = xr_;
        v.e_awonly = xawo; v.e_rr = xrr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_cmd(input cfg_cmd_t c);
        int n = 0;
        cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
        cmd_valid = 1;
        while (!cmd_ready && n < 50) begin @(posedge ACLK); #2; n++; end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge ACLK); #2;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 200) begin @(posedge ACLK); #2; n++; end
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic rsp_pulse();
        rsp_ready = 1;
        @(posedge ACLK); #2;
        rsp_ready = 0;
    endtask

    task automatic set_slave_cfg(input vec_t v);
        s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_ar_dly = v.ar_dly; s_rsp_dly = v.rsp_dly;
        s_resp = v.s_resp; s_rdata = v.s_rdata;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int b_aw, b_w, b_b, b_ar, b_r, b_awo, b_rr;
        v = vecs[i];
        set_slave_cfg(v);
        b_aw = cnt_aw; b_w = cnt_w; b_b = cnt_b; b_ar = cnt_ar; b_r = cnt_r;
        b_awo = cnt_awonly; b_rr = cnt_rr;
        send_cmd(v.cmd);
        wait_rsp();
        chk($sformatf("v%0d_write", i),   rsp_write,   v.cmd.write);
        chk($sformatf("v%0d_rdata", i),   rsp_rdata,   v.e_rdata);
        chk($sformatf("v%0d_resp", i),    rsp_resp,    v.e_resp);
        chk($sformatf("v%0d_timeout", i), rsp_timeout, v.e_to);
        chk($sformatf("v%0d_bus_idle", i), {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready}, 0);
        chk($sformatf("v%0d_aw_hs", i),   cnt_aw - b_aw,  v.e_aw);
        chk($sformatf("v%0d_w_hs", i),    cnt_w - b_w,    v.e_w);
        chk($sformatf("v%0d_b_hs", i),    cnt_b - b_b,    v.e_b);
        chk($sformatf("v%0d_ar_hs", i),   cnt_ar - b_ar,  v.e_ar);
        chk($sformatf("v%0d_r_hs", i),    cnt_r - b_r,    v.e_r);
        chk($sformatf("v%0d_aw_only_cycles", i), cnt_awonly - b_awo, v.e_awonly);
        chk($sformatf("v%0d_rready_cycles", i),  cnt_rr - b_rr,      v.e_rr);
        if (v.e_aw == 1) chk($sformatf("v%0d_awaddr", i), cap_awaddr, v.cmd.addr);
        if (v.e_w == 1)  chk($sformatf("v%0d_wdata", i),  {cap_wstrb, cap_wdata}, {v.cmd.wstrb, v.cmd.wdata});
        if (v.e_ar == 1) chk($sformatf("v%0d_araddr", i), cap_araddr, v.cmd.addr);
        rsp_pulse();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not finish in time");
    end

    initial begin : main
        logic [35:0] snap;
        int bad, n;
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 0; s_rsp_dly = 0; s_resp = 0; s_rdata = 0;

        //           wr  addr   wdata         strb awd      wd ard rspd     sresp  srdata        eresp  erdata        to aw w b ar r awo rr
        vecs[0] = mk(1, 8'h10, 32'hDEADBEEF, 4'hF, 0,       0, 0, 0,       2'b00, 32'h0,        2'b00, 32'h0,        0, 1, 1, 1, 0, 0, 0,  0);
        vecs[1] = mk(1, 8'h20, 32'h12345678, 4'h3, 3,       0, 0, 1,       2'b10, 32'h0,        2'b10, 32'h0,        0, 1, 1, 1, 0, 0, 3,  0);
        vecs[2] = mk(0, 8'h04, 32'h0,        4'h0, 0,       0, 0, 5,       2'b00, 32'h000000A5, 2'b00, 32'h000000A5, 0, 0, 0, 0, 1, 1, 0,  6);
        vecs[3] = mk(0, 8'h08, 32'h0,        4'h0, 0,       0, 2, 0,       2'b11, 32'h12345678, 2'b11, 32'h12345678, 0, 0, 0, 0, 1, 1, 0,  1);
        vecs[4] = mk(1, 8'hFC, 32'h00000001, 4'h1, 0,       2, 0, 3,       2'b00, 32'h0,        2'b00, 32'h0,        0, 1, 1, 1, 0, 0, 0,  0);
        vecs[5] = mk(1, 8'h30, 32'hCAFEF00D, 4'hF, c_NEVER, 0, 0, 0,       2'b00, 32'h0,        2'b10, 32'h0,        1, 0, 1, 0, 0, 0, 15, 0);
        vecs[6] = mk(0, 8'h08, 32'h0,        4'h0, 0,       0, 0, c_NEVER, 2'b00, 32'hFFFFFFFF, 2'b10, 32'h0,        1, 0, 0, 0, 1, 0, 0,  16);

        repeat (3) @(posedge ACLK);
        #2;
        chk("reset_outputs", {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
                              AWVALID, WVALID, BREADY, ARVALID, RREADY, AWADDR, ARADDR, WDATA, WSTRB}, 0);
        chk("axprot", {AWPROT, ARPROT}, 0);
        ARESET = 0;
        #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);
        @(posedge ACLK); #2;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Response back-pressure, then a back-to-back command
        set_slave_cfg(vecs[0]);
        send_cmd(vecs[0].cmd);
        wait_rsp();
        snap = {rsp_write, rsp_rdata, rsp_resp, rsp_timeout};
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge ACLK); #2;
            if (!rsp_valid || cmd_ready || {rsp_write, rsp_rdata, rsp_resp, rsp_timeout} != snap) bad++;
        end
        chk("rsp_hold_stable", bad, 0);
        chk("rsp_hold_fields", snap, {1'b1, 32'h0, 2'b00, 1'b0});
        s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 0; s_rsp_dly = 0; s_resp = 2'b00; s_rdata = 32'h00005A5A;
        cmd_write = 0; cmd_addr = 8'h44; cmd_wdata = 0; cmd_wstrb = 0; cmd_valid = 1;
        rsp_ready = 1;
        @(posedge ACLK); #2;
        rsp_ready = 0;
        chk("b2b_rsp_dropped", rsp_valid, 0);
        chk("b2b_cmd_ready_returns", cmd_ready, 1);
        @(posedge ACLK); #2;
        cmd_valid = 0;
        chk("b2b_accepted", {cmd_ready, ARVALID, ARADDR}, {1'b0, 1'b1, 8'h44});
        wait_rsp();
        chk("b2b_rdata", {rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, {1'b0, 32'h00005A5A, 2'b00, 1'b0});
        rsp_pulse();

        // Reset pulse while AWVALID is pending
        s_aw_dly = c_NEVER; s_w_dly = c_NEVER; s_rsp_dly = 0;
        send_cmd(vecs[0].cmd);
        n = 0;
        while (!AWVALID && n < 20) begin @(posedge ACLK); #2; n++; end
        chk("rst_aw_pending", {AWVALID, WVALID}, 2'b11);
        ARESET = 1;
        #1;
        chk("rst_async_drop", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
        @(posedge ACLK); #2;
        ARESET = 0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK); #2;
            if (rsp_valid || AWVALID || WVALID) bad++;
        end
        chk("rst_no_rsp", bad, 0);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
